// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the external master, the arbiter and the data RAM.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_ubhw;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_stall;

  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [2:0]  ext_ubhw;
  logic [31:0] ext_rdata;
  logic        ext_done;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ubhw;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ubhw,
    output cpu_rdata, cpu_done, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_ubhw,
    output ext_rdata, ext_done,
    output mem_addr, mem_wdata, mem_ubhw, mem_we,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ubhw,
    input  cpu_rdata, cpu_done, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_ubhw,
    input  ext_rdata, ext_done,
    input  mem_addr, mem_wdata, mem_ubhw, mem_we,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: serialises CPU and external accesses onto one RAM port.
// Define DMEM_ARB_STARVE_EN to enable the external-port starvation guard (STARVE_MAX).
module dmem_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  state_t      state_reg;
  logic [1:0]  wait_cnt_reg;
  logic        win_ext_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  ubhw_reg;
  logic        mem_we_reg;
  logic        cpu_done_reg;
  logic        ext_done_reg;
  logic        busy_reg;
  logic [31:0] cpu_rdata_reg;
  logic [31:0] ext_rdata_reg;

  logic        ext_priority;
  logic        grant_ext;
  logic        grant_cpu;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_ubhw;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_reg;

  assign ext_priority = (starve_cnt_reg == STARVE_LIM);

  // Counts CPU wins over a waiting ext master; any ext win or idle ext resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (grant_ext || !bus.ext_req) begin
        starve_cnt_reg <= '0;
      end else if (grant_cpu && (starve_cnt_reg != STARVE_LIM)) begin
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      end
    end
  end
`else
  // Parameter is accepted but has no effect under strict CPU priority.
  logic [31:0] unused_starve_max;
  assign unused_starve_max = 32'(STARVE_MAX);
  assign ext_priority      = 1'b0;
`endif

  assign grant_ext = bus.ext_req && (!bus.cpu_req || ext_priority);
  assign grant_cpu = bus.cpu_req && !grant_ext;

  assign sel_we    = grant_ext ? bus.ext_we    : bus.cpu_we;
  assign sel_addr  = grant_ext ? bus.ext_addr  : bus.cpu_addr;
  assign sel_wdata = grant_ext ? bus.ext_wdata : bus.cpu_wdata;
  assign sel_ubhw  = grant_ext ? bus.ext_ubhw  : bus.cpu_ubhw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      win_ext_reg   <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      ubhw_reg      <= '0;
      mem_we_reg    <= 1'b0;
      cpu_done_reg  <= 1'b0;
      ext_done_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      cpu_rdata_reg <= '0;
      ext_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_cpu || grant_ext) begin
            win_ext_reg <= grant_ext;
            we_reg      <= sel_we;
            addr_reg    <= sel_addr;
            wdata_reg   <= sel_wdata;
            ubhw_reg    <= sel_ubhw;
            mem_we_reg  <= sel_we;
            busy_reg    <= 1'b1;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we_reg <= 1'b0;
          if (we_reg) begin
            cpu_done_reg <= !win_ext_reg;
            ext_done_reg <= win_ext_reg;
            state_reg    <= RESP;
          end else begin
            wait_cnt_reg <= WAIT_LOAD;
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          // Read data is valid in the last WAIT cycle; only the winner's register moves.
          if (wait_cnt_reg == 2'd0) begin
            if (win_ext_reg) begin
              ext_rdata_reg <= bus.mem_rdata;
            end else begin
              cpu_rdata_reg <= bus.mem_rdata;
            end
            cpu_done_reg <= !win_ext_reg;
            ext_done_reg <= win_ext_reg;
            state_reg    <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 2'd1;
          end
        end
        RESP: begin
          cpu_done_reg <= 1'b0;
          ext_done_reg <= 1'b0;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_ubhw  = ubhw_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.ext_rdata = ext_rdata_reg;
  assign bus.cpu_done  = cpu_done_reg;
  assign bus.ext_done  = ext_done_reg;
  assign bus.busy      = busy_reg;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_done_reg;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (RD_LAT=2, STARVE_MAX=4) with a small RAM model.
// Expected grant order depends on whether DMEM_ARB_STARVE_EN is defined for the build.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .RD_LAT    (2),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // RAM model: write on the strobe, read data appears two cycles after the address.
  logic [31:0] mem_model [0:63];
  logic [31:0] rd_pipe0;
  logic [31:0] rd_pipe1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= 32'h0;
      mem_model[16] <= 32'h12345678;
    end else if (bus.mem_we) begin
      mem_model[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    rd_pipe0 <= mem_model[bus.mem_addr[7:2]];
    rd_pipe1 <= rd_pipe0;
  end

  assign bus.mem_rdata = rd_pipe1;

  always @(negedge clk) begin
    if (bus.cpu_done) $display("txn cpu done addr=%08h we=%0b rdata=%08h", bus.mem_addr, bus.mem_we, bus.cpu_rdata);
    if (bus.ext_done) $display("txn ext done addr=%08h rdata=%08h", bus.mem_addr, bus.ext_rdata);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic grant_seq [0:9];
  int   n_grants;
  int   done_cnt;
  logic found;

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.cpu_ubhw  = 3'b0;
    bus.ext_req   = 1'b0;
    bus.ext_we    = 1'b0;
    bus.ext_addr  = 32'h0;
    bus.ext_wdata = 32'h0;
    bus.ext_ubhw  = 3'b0;
    rst = 1'b1;
    repeat (2) tick();

    // Reset state
    check("rst_busy",      32'(bus.busy),     32'h0);
    check("rst_mem_we",    32'(bus.mem_we),   32'h0);
    check("rst_cpu_done",  32'(bus.cpu_done), 32'h0);
    check("rst_ext_done",  32'(bus.ext_done), 32'h0);
    check("rst_cpu_rdata", bus.cpu_rdata,     32'h0);
    check("rst_ext_rdata", bus.ext_rdata,     32'h0);
    check("rst_mem_addr",  bus.mem_addr,      32'h0);
    bus.cpu_req = 1'b1;
    #1;
    check("rst_stall_follows_req", 32'(bus.cpu_stall), 32'h1);
    bus.cpu_req = 1'b0;
    #1;
    check("rst_stall_idle", 32'(bus.cpu_stall), 32'h0);
    rst = 1'b0;
    tick();

    // CPU write 0x10 <- DEADBEEF, request seen at cycle 0
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h10;
    bus.cpu_wdata = 32'hDEADBEEF;
    bus.cpu_ubhw  = 3'b010;
    #1;
    check("wr_c0_stall",  32'(bus.cpu_stall), 32'h1);
    check("wr_c0_mem_we", 32'(bus.mem_we),    32'h0);
    tick();
    check("wr_c1_mem_we",    32'(bus.mem_we),    32'h1);
    check("wr_c1_mem_addr",  bus.mem_addr,       32'h10);
    check("wr_c1_mem_wdata", bus.mem_wdata,      32'hDEADBEEF);
    check("wr_c1_mem_ubhw",  32'(bus.mem_ubhw),  32'h2);
    check("wr_c1_stall",     32'(bus.cpu_stall), 32'h1);
    check("wr_c1_busy",      32'(bus.busy),      32'h1);
    tick();
    check("wr_c2_mem_we", 32'(bus.mem_we),    32'h0);
    check("wr_c2_done",   32'(bus.cpu_done),  32'h1);
    check("wr_c2_stall",  32'(bus.cpu_stall), 32'h0);
    bus.cpu_req = 1'b0;
    tick();
    check("wr_c3_done",     32'(bus.cpu_done), 32'h0);
    check("wr_c3_busy",     32'(bus.busy),     32'h0);
    check("wr_c3_addr_hold", bus.mem_addr,     32'h10);
    check("wr_ram_content", mem_model[4],      32'hDEADBEEF);

    // CPU read 0x40 (RAM holds 12345678), done expected at cycle 4
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h40;
    bus.cpu_ubhw = 3'b010;
    tick();
    check("rd_c1_mem_we", 32'(bus.mem_we), 32'h0);
    check("rd_c1_busy",   32'(bus.busy),   32'h1);
    tick();
    tick();
    check("rd_c3_done",      32'(bus.cpu_done), 32'h0);
    check("rd_c3_addr_hold", bus.mem_addr,      32'h40);
    tick();
    check("rd_c4_done",      32'(bus.cpu_done), 32'h1);
    check("rd_c4_rdata",     bus.cpu_rdata,     32'h12345678);
    check("rd_c4_ext_rdata", bus.ext_rdata,     32'h0);
    bus.cpu_req = 1'b0;
    tick();
    check("rd_c5_done",       32'(bus.cpu_done), 32'h0);
    check("rd_c5_rdata_hold", bus.cpu_rdata,     32'h12345678);

    // CPU write 0x20 then ext read of 0x20, both requesting at cycle 0
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h20;
    bus.cpu_wdata = 32'hCAFEF00D;
    bus.ext_req   = 1'b1;
    bus.ext_we    = 1'b0;
    bus.ext_addr  = 32'h20;
    bus.ext_ubhw  = 3'b100;
    tick();
    check("wx_c1_mem_we",   32'(bus.mem_we), 32'h1);
    check("wx_c1_mem_addr", bus.mem_addr,    32'h20);
    tick();
    check("wx_c2_cpu_done", 32'(bus.cpu_done), 32'h1);
    check("wx_c2_ext_done", 32'(bus.ext_done), 32'h0);
    bus.cpu_req = 1'b0;
    tick();
    check("wx_c3_cpu_done", 32'(bus.cpu_done), 32'h0);
    check("wx_c3_ext_done", 32'(bus.ext_done), 32'h0);
    tick();
    check("wx_c4_mem_we",   32'(bus.mem_we),   32'h0);
    check("wx_c4_mem_ubhw", 32'(bus.mem_ubhw), 32'h4);
    tick();
    tick();
    check("wx_c6_ext_done", 32'(bus.ext_done), 32'h0);
    tick();
    check("wx_c7_ext_done",  32'(bus.ext_done), 32'h1);
    check("wx_c7_ext_rdata", bus.ext_rdata,     32'hCAFEF00D);
    check("wx_c7_cpu_done",  32'(bus.cpu_done), 32'h0);
    check("wx_c7_cpu_rdata", bus.cpu_rdata,     32'h12345678);
    bus.ext_req = 1'b0;
    tick();

    // Reset in the ISSUE cycle of a write: strobe must drop without a clock edge
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h30;
    bus.cpu_wdata = 32'h55AA55AA;
    tick();
    check("rw_c1_mem_we", 32'(bus.mem_we), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rw_async_mem_we", 32'(bus.mem_we), 32'h0);
    check("rw_async_busy",   32'(bus.busy),   32'h0);
    bus.cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Reset while the read is in WAIT: no done pulse may ever follow
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h40;
    tick();
    tick();
    check("rr_c2_busy", 32'(bus.busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rr_async_busy",   32'(bus.busy),   32'h0);
    check("rr_async_mem_we", 32'(bus.mem_we), 32'h0);
    bus.cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.cpu_done) done_cnt++;
    end
    check("rr_no_done",      32'(done_cnt),  32'h0);
    check("rr_rdata_reset",  bus.cpu_rdata,  32'h0);

    // Both ports held requesting writes: record the grant order
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h80;
    bus.cpu_wdata = 32'h1;
    bus.ext_req   = 1'b1;
    bus.ext_we    = 1'b1;
    bus.ext_addr  = 32'h84;
    bus.ext_wdata = 32'h2;
    n_grants = 0;
    for (int cyc = 0; cyc < 100 && n_grants < 10; cyc++) begin
      tick();
      if (bus.cpu_done && bus.ext_done) check("st_overlap", 32'h1, 32'h0);
      if (bus.cpu_done) begin
        grant_seq[n_grants] = 1'b0;
        n_grants++;
      end else if (bus.ext_done) begin
        grant_seq[n_grants] = 1'b1;
        n_grants++;
      end
    end
    check("st_grant_count", 32'(n_grants), 32'd10);
    for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_STARVE_EN
      check($sformatf("st_grant_%0d", i), 32'(grant_seq[i]), ((i % 5) == 4) ? 32'h1 : 32'h0);
`else
      check($sformatf("st_grant_%0d", i), 32'(grant_seq[i]), 32'h0);
`endif
    end

    // Drop cpu_req at the next CPU completion: ext must win the following IDLE cycle
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      tick();
      if (bus.cpu_done) found = 1'b1;
    end
    check("dr_cpu_done_seen", 32'(found), 32'h1);
    bus.cpu_req = 1'b0;
    tick();
    check("dr_c1_ext_done", 32'(bus.ext_done), 32'h0);
    tick();
    check("dr_c2_mem_we",   32'(bus.mem_we),   32'h1);
    check("dr_c2_mem_addr", bus.mem_addr,      32'h84);
    tick();
    check("dr_c3_ext_done", 32'(bus.ext_done), 32'h1);
    check("dr_c3_cpu_done", 32'(bus.cpu_done), 32'h0);
    bus.ext_req = 1'b0;
    tick();
    check("dr_c4_busy", 32'(bus.busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
